// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder with a byte register bank, oversampled entirely in the wb_clk_i domain.
// Host sends {rw, addr} then data bytes; the address auto-increments and wraps over the bank.
`timescale 1ns/1ps

module spi_slave_regs #(
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        spi_sck_i,
    input  logic                        spi_cs_n_i,
    input  logic                        spi_mosi_i,
    output logic                        spi_miso_o,
    output logic                        spi_miso_oe_o,
    input  logic [7:0]                  status_i,
    output logic                        wr_stb_o,
    output logic [ADDR_W-1:0]           wr_addr_o,
    output logic [7:0]                  wr_data_o,
    output logic [8*(2**ADDR_W)-1:0]    regs_o
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state;
    logic [2:0]          bit_cnt;
    logic [6:0]          rx_shift;
    logic [7:0]          tx_shift;
    logic                rw;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          mem [NREGS];

    // Two synchronizer stages plus one history stage for edge detection.
    logic [2:0] sck_pipe, cs_pipe, mosi_pipe;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sck_pipe  <= 3'b000;
            cs_pipe   <= 3'b111;
            mosi_pipe <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous
            // stage's old value, which is what makes this a real shift chain.
            sck_pipe  <= {sck_pipe[1:0],  spi_sck_i};
            cs_pipe   <= {cs_pipe[1:0],   spi_cs_n_i};
            mosi_pipe <= {mosi_pipe[1:0], spi_mosi_i};
        end
    end

    logic sck_sync, sck_d, cs_sync, cs_d, mosi_sync;
    assign sck_sync  = sck_pipe[1];
    assign sck_d     = sck_pipe[2];
    assign cs_sync   = cs_pipe[1];
    assign cs_d      = cs_pipe[2];
    assign mosi_sync = mosi_pipe[1];

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    assign sck_rise = sck_sync & ~sck_d;
    assign sck_fall = ~sck_sync & sck_d;
    assign cs_rise  = cs_sync & ~cs_d;
    assign cs_fall  = ~cs_sync & cs_d;

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] addr_next;
    assign rx_byte   = {rx_shift, mosi_sync};
    assign cmd_addr  = rx_byte[ADDR_W-1:0];
    assign addr_next = addr + 1'b1;

    assign spi_miso_o    = tx_shift[7];
    assign spi_miso_oe_o = ~cs_sync;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            rx_shift  <= 7'd0;
            tx_shift  <= 8'd0;
            rw        <= 1'b0;
            addr      <= '0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= 8'd0;
            // NOTE: the register bank is architecturally visible on regs_o, so it
            // is reset like any other state rather than left as an uninitialised RAM.
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else begin
            wr_stb_o <= 1'b0;
            if (cs_rise) begin
                // Deselect wins over any SCK edge seen in the same cycle.
                state   <= IDLE;
                bit_cnt <= 3'd0;
            end else if (cs_fall) begin
                state    <= CMD;
                bit_cnt  <= 3'd0;
                tx_shift <= status_i;
            end else if (state != IDLE) begin
                if (sck_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state == CMD) begin
                            rw       <= rx_byte[7];
                            addr     <= cmd_addr;
                            tx_shift <= mem[cmd_addr];
                            state    <= DATA;
                        end else if (rw) begin
                            mem[addr] <= rx_byte;
                            wr_stb_o  <= 1'b1;
                            wr_addr_o <= addr;
                            wr_data_o <= rx_byte;
                            addr      <= addr_next;
                            tx_shift  <= 8'h00;
                        end else begin
                            addr     <= addr_next;
                            tx_shift <= mem[addr_next];
                        end
                    end
                end else if (sck_fall && bit_cnt != 3'd0) begin
                    // At a byte boundary the freshly loaded MSB must survive this fall.
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign regs_o[8*g +: 8] = mem[g];
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: a bit-banged SPI master driven from a vector table,
// plus hand sequences for abort, mid-transaction reset and a randomized timing sweep.
`timescale 1ns/1ps

module tb_spi_slave_regs;

    localparam int CLK_P = 10;
    localparam int HALF  = 3 * CLK_P;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sck = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic [7:0]   status = 8'h00;
    logic         miso, miso_oe, wr_stb;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic [127:0] regs;

    spi_slave_regs #(.ADDR_W(4), .RESET_VAL(8'h00)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .spi_sck_i     (sck),
        .spi_cs_n_i    (cs_n),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .status_i      (status),
        .wr_stb_o      (wr_stb),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .regs_o        (regs)
    );

    always #(CLK_P/2) clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor, sampled mid-cycle.
    logic [3:0] sa_q[$];
    logic [7:0] sd_q[$];
    logic       stb_prev = 1'b0;
    int         stb_double = 0;

    always @(negedge clk) begin
        if (wr_stb) begin
            sa_q.push_back(wr_addr);
            sd_q.push_back(wr_data);
        end
        if (wr_stb && stb_prev) stb_double++;
        stb_prev = wr_stb;
    end

    logic [7:0] model [16];

    function automatic logic [127:0] model_flat();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = model[i];
        return r;
    endfunction

    // Every SPI edge in a transaction keeps the random phase chosen here.
    task automatic begin_xfer();
        @(posedge clk);
        #($urandom_range(1, 8));
        cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic end_xfer();
        #(HALF);
        cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        int skew;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            skew = $urandom_range(0, 8);
            #(skew);
            mosi = tx[7-i];
            #(HALF - skew);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            #(HALF);
            sck = 1'b0;
        end
    endtask

    typedef struct packed {
        logic [31:0]     n;
        logic [2:0][7:0] tx;
        logic [7:0]      status;
        logic [2:0][7:0] rx;
        logic [31:0]     n_stb;
        logic [1:0][3:0] sa;
        logic [1:0][7:0] sd;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [7:0] t0, t1, t2, st,
                                input logic [7:0] r0, r1, r2, input int n_stb,
                                input logic [3:0] a0, input logic [7:0] d0,
                                input logic [3:0] a1, input logic [7:0] d1);
        vec_t v;
        v.n = n;   v.status = st;   v.n_stb = n_stb;
        v.tx[0] = t0; v.tx[1] = t1; v.tx[2] = t2;
        v.rx[0] = r0; v.rx[1] = r1; v.rx[2] = r2;
        v.sa[0] = a0; v.sd[0] = d0; v.sa[1] = a1; v.sd[1] = d1;
        return v;
    endfunction

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] d;
        logic [3:0] start;
        int         base;

        // write 3,4 / read back / wrap write / wrap read / high cmd bits ignored
        vecs[0] = mk(3, 8'h83, 8'h5A, 8'hC3, 8'hA5, 8'hA5, 8'h00, 8'h00, 2, 4'd3, 8'h5A, 4'd4, 8'hC3);
        vecs[1] = mk(3, 8'h03, 8'h00, 8'h00, 8'h81, 8'h81, 8'h5A, 8'hC3, 0, 4'd0, 8'h00, 4'd0, 8'h00);
        vecs[2] = mk(3, 8'h8F, 8'h11, 8'h22, 8'h3C, 8'h3C, 8'h00, 8'h00, 2, 4'd15, 8'h11, 4'd0, 8'h22);
        vecs[3] = mk(3, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 0, 4'd0, 8'h00, 4'd0, 8'h00);
        vecs[4] = mk(2, 8'hB5, 8'h66, 8'h00, 8'h5C, 8'h5C, 8'h00, 8'h00, 1, 4'd5, 8'h66, 4'd0, 8'h00);
        vecs[5] = mk(3, 8'h74, 8'h00, 8'h00, 8'hE7, 8'hE7, 8'hC3, 8'h66, 0, 4'd0, 8'h00, 4'd0, 8'h00);

        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_miso",    miso,    1'b0);
        check("rst_oe",      miso_oe, 1'b0);
        check("rst_stb",     wr_stb,  1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_regs",    regs,    model_flat());
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < NVEC; v++) begin
            base   = sa_q.size();
            status = vecs[v].status;
            begin_xfer();
            @(negedge clk);
            check($sformatf("v%0d_oe_sel", v), miso_oe, 1'b1);
            for (int b = 0; b < int'(vecs[v].n); b++) begin
                spi_bits(vecs[v].tx[b], 8, rx);
                check($sformatf("v%0d_miso%0d", v, b), rx, vecs[v].rx[b]);
            end
            end_xfer();
            check($sformatf("v%0d_oe_desel", v), miso_oe, 1'b0);
            check($sformatf("v%0d_stb_cnt", v), sa_q.size() - base, vecs[v].n_stb);
            for (int j = 0; j < int'(vecs[v].n_stb) && base + j < sa_q.size(); j++) begin
                check($sformatf("v%0d_stb_addr%0d", v, j), sa_q[base+j], vecs[v].sa[j]);
                check($sformatf("v%0d_stb_data%0d", v, j), sd_q[base+j], vecs[v].sd[j]);
                model[vecs[v].sa[j]] = vecs[v].sd[j];
            end
            check($sformatf("v%0d_regs", v), regs, model_flat());
        end

        // Abort: partial byte after the command must leave no trace.
        base   = sa_q.size();
        status = 8'h42;
        begin_xfer();
        spi_bits(8'h81, 8, rx);
        check("abort_status", rx, 8'h42);
        spi_bits(8'b1010_1000, 5, rx);
        end_xfer();
        check("abort_stb_cnt", sa_q.size() - base, 0);
        check("abort_regs", regs, model_flat());

        base = sa_q.size();
        begin_xfer();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'h77, 8, rx);
        end_xfer();
        check("after_abort_stb_cnt", sa_q.size() - base, 1);
        if (sa_q.size() > base) begin
            check("after_abort_stb_addr", sa_q[base], 4'd1);
            check("after_abort_stb_data", sd_q[base], 8'h77);
        end
        model[1] = 8'h77;
        check("after_abort_regs", regs, model_flat());

        // Reset in the middle of a data byte.
        begin_xfer();
        spi_bits(8'h86, 8, rx);
        spi_bits(8'hAA, 4, rx);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        check("midrst_regs",    regs,    model_flat());
        check("midrst_miso",    miso,    1'b0);
        check("midrst_oe",      miso_oe, 1'b0);
        check("midrst_stb",     wr_stb,  1'b0);
        check("midrst_wr_addr", wr_addr, 4'd0);
        check("midrst_wr_data", wr_data, 8'h00);
        cs_n = 1'b1;
        sck  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("postrst_oe", miso_oe, 1'b0);

        base   = sa_q.size();
        status = 8'h5E;
        begin_xfer();
        spi_bits(8'h82, 8, rx);
        check("postrst_wr_status", rx, 8'h5E);
        spi_bits(8'h99, 8, rx);
        end_xfer();
        begin_xfer();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("postrst_readback", rx, 8'h99);
        end_xfer();
        check("postrst_stb_cnt", sa_q.size() - base, 1);
        model[2] = 8'h99;
        check("postrst_regs", regs, model_flat());

        // Timing sweep: random phase and MOSI skew, 256 write/read-back bytes.
        for (int r = 0; r < 16; r++) begin
            start  = 4'($urandom_range(0, 15));
            status = 8'($urandom);
            base   = sa_q.size();
            begin_xfer();
            spi_bits({4'h8, start}, 8, rx);
            check($sformatf("rnd%0d_status", r), rx, status);
            for (int i = 0; i < 16; i++) begin
                d = 8'($urandom);
                spi_bits(d, 8, rx);
                model[(int'(start) + i) % 16] = d;
            end
            end_xfer();
            check($sformatf("rnd%0d_stb_cnt", r), sa_q.size() - base, 16);
            begin_xfer();
            spi_bits({4'h0, start}, 8, rx);
            for (int i = 0; i < 16; i++) begin
                spi_bits(8'($urandom), 8, rx);
                check($sformatf("rnd%0d_rd%0d", r, i), rx, model[(int'(start) + i) % 16]);
            end
            end_xfer();
            check($sformatf("rnd%0d_regs", r), regs, model_flat());
        end

        check("no_back_to_back_stb", stb_double, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
